// File: rtl/fft_pkg.sv
// Shared FFT definitions: default word size, complex word layout, reader
// FSM states and the bit-reversal helper used by address generators.
package fft_pkg;

    localparam int unsigned WORD_SIZE_DEFAULT = 16;

    // A complex word is {real, imag}; a part's lsb is its slot times WORD_SIZE.
    localparam int unsigned CPLX_RE_SLOT = 1;
    localparam int unsigned CPLX_IM_SLOT = 0;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_STREAM = 2'd1,
        RD_DONE   = 2'd2
    } reader_state_t;

    // Reverse the low 'width' bits of value; upper bits of the result are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < width) begin
                r[5'(width - 1 - i)] = value[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_skid2.sv
// Two-entry FIFO-ordered valid/ready buffer exposing its occupancy.
// The writer is responsible for never pushing into a full buffer.
module fft_out_skid2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             pop;

    assign pop      = rd_valid & rd_ready;
    assign rd_valid = (count != 2'd0);
    assign rd_data  = head;

    // Entry storage and occupancy; head always holds the oldest entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            case ({wr_valid, pop})
                2'b10: begin
                    if (count == 2'd0) head <= wr_data;
                    else               tail <= wr_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= wr_data;
                    end else begin
                        head <= tail;
                        tail <= wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fft_output_reader.sv
// FFT readout: after start, reads the frame at bitrev(k) for k = 0..N-1 and
// streams it in natural order over valid/ready with a two-entry buffer.
// Optional build macro FFT_OUTPUT_SCALE_EN divides each part by N (arithmetic
// shift by ADDR_WIDTH) on the buffer write path.
module fft_output_reader
    import fft_pkg::*;
#(
    parameter int unsigned N          = 32,
    parameter int unsigned WORD_SIZE  = WORD_SIZE_DEFAULT,
    parameter int unsigned ADDR_WIDTH = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic [2*WORD_SIZE-1:0] rd_data,
    output logic [2*WORD_SIZE-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]  out_index,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned CPLX_W = 2 * WORD_SIZE;

    reader_state_t         state;
    reader_state_t         state_next;
    logic [ADDR_WIDTH:0]   rd_cnt;
    logic [ADDR_WIDTH-1:0] out_cnt;
    logic                  rd_pend;
    logic [1:0]            occ;
    logic [CPLX_W-1:0]     wr_data;
    logic                  launch;
    logic                  issue;
    logic                  pop;
    logic [2:0]            credit;

    // Entries the buffer will hold once this cycle's pop and pending read land.
    assign pop    = out_valid & out_ready;
    assign credit = 3'(occ) + 3'(rd_pend) - 3'(pop);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RD_IDLE;
        else       state <= state_next;
    end

    // Next state, frame launch and read issue; rd_cnt saturates at N (top bit set).
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        issue      = 1'b0;
        case (state)
            RD_IDLE, RD_DONE: begin
                if (start) begin
                    state_next = RD_STREAM;
                    launch     = 1'b1;
                end
            end
            RD_STREAM: begin
                issue = !rd_cnt[ADDR_WIDTH] && (credit < 3'd2);
                if (pop && out_last) state_next = RD_DONE;
            end
            default: state_next = RD_IDLE;
        endcase
    end

    // Read and output counters plus the one-cycle read-latency tracker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt  <= '0;
            out_cnt <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= issue;
            if (launch) begin
                rd_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (issue) rd_cnt  <= rd_cnt + 1'b1;
                if (pop)   out_cnt <= out_cnt + 1'b1;
            end
        end
    end

    assign rd_en     = issue;
    assign rd_addr   = ADDR_WIDTH'(bitrev(32'(rd_cnt[ADDR_WIDTH-1:0]), ADDR_WIDTH));
    assign out_index = out_cnt;
    assign out_last  = out_valid && (out_cnt == ADDR_WIDTH'(N - 1));
    assign busy      = (state == RD_STREAM);
    assign done      = (state == RD_DONE);

`ifdef FFT_OUTPUT_SCALE_EN
    localparam int unsigned RE_LSB = WORD_SIZE * CPLX_RE_SLOT;
    localparam int unsigned IM_LSB = WORD_SIZE * CPLX_IM_SLOT;

    logic signed [WORD_SIZE-1:0] rd_re;
    logic signed [WORD_SIZE-1:0] rd_im;

    assign rd_re = rd_data[RE_LSB +: WORD_SIZE];
    assign rd_im = rd_data[IM_LSB +: WORD_SIZE];
    assign wr_data[RE_LSB +: WORD_SIZE] = rd_re >>> ADDR_WIDTH;
    assign wr_data[IM_LSB +: WORD_SIZE] = rd_im >>> ADDR_WIDTH;
`else
    assign wr_data = rd_data;
`endif

    fft_out_skid2 #(
        .WIDTH(CPLX_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (rd_pend),
        .wr_data  (wr_data),
        .rd_ready (out_ready),
        .rd_valid (out_valid),
        .rd_data  (out_data),
        .count    (occ)
    );

endmodule

// File: tb/tb_fft_output_reader.sv
// Bench for fft_output_reader: an N=8 and an N=32 instance, a synchronous
// memory model per instance, a frame-level reference model checked every
// cycle, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_fft_output_reader;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;

    logic        start8 = 1'b0, rdy8 = 1'b1;
    logic        rd_en8, ov8, ol8, busy8, done8;
    logic [2:0]  rd_addr8, oi8;
    logic [31:0] rd_data8 = '0, od8;

    logic        start32 = 1'b0, rdy32 = 1'b1;
    logic        rd_en32, ov32, ol32, busy32, done32;
    logic [4:0]  rd_addr32, oi32;
    logic [31:0] rd_data32 = '0, od32;

    int n_vec  = 0;
    int n_fail = 0;
    int mode32 = 1;

    always #5 clk = ~clk;

    fft_output_reader #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .rd_en(rd_en8), .rd_addr(rd_addr8),
        .rd_data(rd_data8), .out_data(od8), .out_index(oi8), .out_valid(ov8),
        .out_ready(rdy8), .out_last(ol8), .busy(busy8), .done(done8)
    );

    fft_output_reader #(.N(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .rd_en(rd_en32), .rd_addr(rd_addr32),
        .rd_data(rd_data32), .out_data(od32), .out_index(oi32), .out_valid(ov32),
        .out_ready(rdy32), .out_last(ol32), .busy(busy32), .done(done32)
    );

    task automatic chk(input int inst, input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got 0x%0h, expected 0x%0h", nm, inst, $time, act, expv);
        end
    endtask

    function automatic int unsigned tb_bitrev(input int unsigned v, input int unsigned w);
        int unsigned r = 0;
        int unsigned x = v;
        for (int j = 0; j < int'(w); j++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    function automatic logic [31:0] mem_word(input int mode, input int unsigned a);
        logic [15:0] re, im;
        case (mode)
            0:       begin re = 16'(a);            im = 16'(-int'(a)); end
            1:       begin re = 16'(a * 977 + 11); im = 16'(65535 - a * 513); end
            default: begin re = 16'h0100;          im = 16'hFF00; end
        endcase
        return {re, im};
    endfunction

    function automatic logic [31:0] exp_out(input int inst, input int unsigned a);
        logic [31:0]        w;
        logic signed [15:0] re, im;
        w  = mem_word((inst == 0) ? 0 : mode32, a);
        re = w[31:16];
        im = w[15:0];
`ifdef FFT_OUTPUT_SCALE_EN
        re = re >>> ((inst == 0) ? 3 : 5);
        im = im >>> ((inst == 0) ? 3 : 5);
`endif
        return {re, im};
    endfunction

    // Synchronous sample memories: data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en8)  rd_data8  <= mem_word(0, 32'(rd_addr8));
        if (rd_en32) rd_data32 <= mem_word(mode32, 32'(rd_addr32));
    end

    // Reference model state per instance: phase 0 idle, 1 streaming, 2 done.
    int unsigned k_m[2]     = '{0, 0};
    int unsigned iss_m[2]   = '{0, 0};
    int          ph_m[2]    = '{0, 0};
    bit          stall_m[2] = '{0, 0};
    logic [31:0] pd_m[2];
    logic [31:0] pi_m[2];
    logic        pl_m[2];

    // Every-cycle comparison of both instances against the frame model.
    always @(negedge clk) begin : compare
        logic        v, r, l, re_, st, bz, dn;
        logic [31:0] d, idx, ra;
        int unsigned n, aw;
        int          ph0;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                v = ov8; r = rdy8; l = ol8; re_ = rd_en8; st = start8; bz = busy8; dn = done8;
                d = od8; idx = 32'(oi8); ra = 32'(rd_addr8); n = 8; aw = 3;
            end else begin
                v = ov32; r = rdy32; l = ol32; re_ = rd_en32; st = start32; bz = busy32; dn = done32;
                d = od32; idx = 32'(oi32); ra = 32'(rd_addr32); n = 32; aw = 5;
            end
            if (reset) begin
                chk(i, "reset_outputs", 64'(|{v, l, re_, bz, dn, d, idx, ra}), 64'(0));
                ph_m[i] = 0; k_m[i] = 0; iss_m[i] = 0; stall_m[i] = 1'b0;
            end else begin
                ph0 = ph_m[i];
                chk(i, "busy", 64'(bz), 64'(ph0 == 1));
                chk(i, "done", 64'(dn), 64'(ph0 == 2));
                if (ph0 != 1) begin
                    chk(i, "idle_valid", 64'(v), 64'(0));
                    chk(i, "idle_rd_en", 64'(re_), 64'(0));
                end else begin
                    if (re_) begin
                        chk(i, "rd_addr", 64'(ra), 64'(tb_bitrev(iss_m[i], aw)));
                        chk(i, "rd_overrun", 64'(iss_m[i] < n), 64'(1));
                        iss_m[i]++;
                    end
                    if (stall_m[i]) begin
                        chk(i, "stall_valid", 64'(v), 64'(1));
                        chk(i, "stall_data", 64'(d), 64'(pd_m[i]));
                        chk(i, "stall_index", 64'(idx), 64'(pi_m[i]));
                        chk(i, "stall_last", 64'(l), 64'(pl_m[i]));
                    end
                    if (v) begin
                        chk(i, "out_index", 64'(idx), 64'(k_m[i]));
                        chk(i, "out_data", 64'(d), 64'(exp_out(i, tb_bitrev(k_m[i], aw))));
                        chk(i, "out_last", 64'(l), 64'(k_m[i] == n - 1));
                    end
                    if (v && r) k_m[i]++;
                    chk(i, "credit", 64'((iss_m[i] - k_m[i]) <= 2), 64'(1));
                    stall_m[i] = v && !r;
                    pd_m[i] = d; pi_m[i] = idx; pl_m[i] = l;
                    if (v && r && k_m[i] == n) ph_m[i] = 2;
                end
                if (st && ph0 != 1) begin
                    ph_m[i] = 1; k_m[i] = 0; iss_m[i] = 0; stall_m[i] = 1'b0;
                end
            end
        end
    end

    task automatic pulse_start32();
        @(posedge clk); #1 start32 = 1'b1;
        @(posedge clk); #1 start32 = 1'b0;
    endtask

    task automatic run32(input bit rnd, input int budget, input string tag);
        int c = 0;
        while (!done32 && c < budget) begin
            @(posedge clk); #1;
            if (rnd) rdy32 = 1'($urandom_range(0, 1));
            c++;
        end
        chk(1, {tag, "_done_in_budget"}, 64'(done32), 64'(1));
        chk(1, {tag, "_transfers"}, 64'(k_m[1]), 64'(32));
        rdy32 = 1'b1;
    endtask

    task automatic wait_k32(input int unsigned want, input int budget);
        int c = 0;
        while (k_m[1] < want && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(1, "wait_k", 64'(k_m[1] >= want), 64'(1));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          reals[$];
        int          exp_re[8];
        int          lastpos = -1;
        int          nlast   = 0;
        int          cnt;
        int          c;
`ifdef FFT_OUTPUT_SCALE_EN
        exp_re = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
        exp_re = '{0, 4, 2, 6, 1, 5, 3, 7};
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // N=8 natural-order frame with literal latency and sequence checks.
        @(posedge clk); #1 start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        @(negedge clk);
        chk(0, "n8_rd_en_after_e0", 64'(rd_en8), 64'(1));
        chk(0, "n8_valid_after_e0", 64'(ov8), 64'(0));
        @(negedge clk);
        chk(0, "n8_valid_after_e1", 64'(ov8), 64'(0));
        for (int e = 2; e <= 10; e++) begin
            @(negedge clk);
            if (e == 2) chk(0, "n8_valid_after_e2", 64'(ov8), 64'(1));
            if (ov8 && rdy8) begin
                reals.push_back(int'(od8[31:16]));
                if (ol8) begin
                    nlast++;
                    lastpos = reals.size() - 1;
                end
            end
            if (e == 9)  chk(0, "n8_done_after_e9", 64'(done8), 64'(0));
            if (e == 10) chk(0, "n8_done_after_e10", 64'(done8), 64'(1));
        end
        chk(0, "n8_transfer_count", 64'(reals.size()), 64'(8));
        for (int j = 0; j < 8; j++) begin
            if (j < reals.size()) chk(0, $sformatf("n8_real_%0d", j), 64'(reals[j]), 64'(exp_re[j]));
        end
        chk(0, "n8_last_position", 64'(lastpos), 64'(7));
        chk(0, "n8_last_count", 64'(nlast), 64'(1));

        // N=32 under random backpressure.
        mode32 = 1;
        pulse_start32();
        run32(1'b1, 600, "bp");

        // start during STREAM at bin 5 is ignored.
        c = 0;
        pulse_start32();
        while (!(ov32 && oi32 == 5'd5) && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk(1, "reach_bin5", 64'(ov32 && oi32 == 5'd5), 64'(1));
        pulse_start32();
        run32(1'b0, 200, "restart_ignored");

        // start in DONE launches a fresh frame from k=0.
        pulse_start32();
        @(negedge clk);
        chk(1, "relaunch_busy", 64'(busy32), 64'(1));
        chk(1, "relaunch_index", 64'(oi32), 64'(0));
        run32(1'b0, 200, "relaunch");

        // Asynchronous reset mid-frame, then a full frame.
        pulse_start32();
        wait_k32(4, 100);
        @(posedge clk); #2 reset = 1'b1;
        #1;
        chk(1, "async_reset_zero", 64'(|{ov32, ol32, rd_en32, busy32, done32, od32, oi32, rd_addr32}), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        pulse_start32();
        run32(1'b0, 200, "after_reset");

        // Downstream stalled for 20 cycles right after start.
        rdy32 = 1'b0;
        pulse_start32();
        cnt = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (rd_en32) cnt++;
        end
        chk(1, "stall20_rd_en_pulses", 64'(cnt), 64'(2));
        @(posedge clk); #1 rdy32 = 1'b1;
        run32(1'b0, 200, "stall20_drain");

        // Scaling literal.
        mode32 = 2;
        pulse_start32();
        c = 0;
        while (!ov32 && c < 20) begin
            @(negedge clk);
            c++;
        end
`ifdef FFT_OUTPUT_SCALE_EN
        chk(1, "scale_literal", 64'(od32), 64'(32'h0008FFF8));
`else
        chk(1, "scale_literal", 64'(od32), 64'(32'h0100FF00));
`endif
        run32(1'b0, 200, "scale");

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_output_reader.md
Name: fft_output_reader

Overview:
- Readout stage at the far end of the FFT datapath. The input stage writes butterfly results into the shared sample memory; this block reads the finished frame back out of that memory.
- After the core signals completion, it walks indices k = 0..N-1 and reads memory at bitrev(k), so the output comes out in natural frequency order.
- Streams one complex bin per cycle over a valid/ready interface and tolerates downstream backpressure without losing or duplicating samples.

Parameters:
- N, 32: FFT size (points). Must be a power of two, 4 or greater.
- WORD_SIZE, 16: width of each real and imaginary part, signed two's complement.
- ADDR_WIDTH, $clog2(N): width of memory addresses and bin indices.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse from the FFT core: frame in memory is complete.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_WIDTH  memory read address.
- rd_data  in  2*WORD_SIZE  {real, imag}; valid exactly one cycle after rd_en.
- out_data  out  2*WORD_SIZE  {real, imag} of the current bin.
- out_index  out  ADDR_WIDTH  natural-order bin number k of out_data.
- out_valid  out  1  out_data, out_index and out_last are valid.
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid & out_ready.
- out_last  out  1  high with bin N-1.
- busy  out  1  high in STREAM.
- done  out  1  high in DONE.

Behaviour:
- Reset values: every output is 0. State = IDLE. All counters and buffer entries are cleared.
- Reset mid-frame: the partial frame is discarded. There is no resume.

State machine:
- IDLE -> STREAM when start=1. The read counter and output counter are cleared.
- STREAM -> DONE on the transfer where out_last=1.
- DONE -> STREAM on start; the new frame restarts at k=0. done stays high until then.
- start is ignored while in STREAM.

Read issue:
- In STREAM, the block issues rd_en=1, rd_addr=bitrev(rd_cnt) and increments rd_cnt when both hold:
  - rd_cnt < N
  - buffer occupancy + reads in flight < 2
- rd_cnt saturates at N; no reads are issued past N-1.
- bitrev reverses the ADDR_WIDTH bits. Example, N=8: 1 -> 4, 3 -> 6.

Output buffer:
- Two entries, FIFO order. rd_data is written one cycle after rd_en.
- out_valid = buffer not empty. out_data, out_index and out_last come from the head entry.
- out_index and out_last are generated by a separate output counter that increments on each transfer.
- While out_valid=1 and out_ready=0, out_data, out_index and out_last hold stable.
- A simultaneous write and pop in the same cycle is legal; occupancy is unchanged.

Latency and throughput:
- start is sampled at edge E0. rd_en is high after E0. out_valid is high after E2.
- With out_ready held at 1: one transfer per cycle, so N transfers in N consecutive cycles. The last transfer is in the cycle after E(N+1); done=1 after E(N+2).

Optional Feature:
- Macro: FFT_OUTPUT_SCALE_EN.
- Defined: real and imaginary are each arithmetically right-shifted by ADDR_WIDTH (divide by N, truncation toward -inf). The shift is applied on the buffer write path and adds no cycles.
- Undefined: rd_data passes through unmodified.
- Latency and handshake are identical in both builds.

Decomposition:
- Package fft_pkg holds:
  - WORD_SIZE default;
  - the complex word layout ({real, imag} slice positions);
  - the function bitrev(value, width), shared with the butterfly address generator.
- One sub-module, fft_out_skid2: the generic two-entry valid/ready buffer with occupancy output.
- The FSM, the read and output counters, and scaling stay in the top module.

Test Plan:
- N=8, mem[a] = {a, -a}, out_ready=1, start pulse:
  - out_data real sequence is 0,4,2,6,1,5,3,7 and out_index is 0..7;
  - out_last is high only on the 8th transfer;
  - out_valid first rises after E2; done rises after E10.
- Backpressure, N=32, out_ready driven pseudo-random at 50%:
  - exactly 32 transfers in bitrev order, no gaps or duplicates;
  - out_data stable during every stall;
  - rd_en never issued while occupancy + in-flight = 2.
- start pulsed again during STREAM at bin 5: ignored, and the frame completes normally. A start in DONE launches a new frame from k=0.
- reset asserted asynchronously after bin 3 transfers:
  - all outputs go to 0 immediately;
  - the next start delivers a full frame starting at out_index 0.
- out_ready=0 for 20 cycles right after start: rd_en pulses exactly twice, then stops. On release, all N bins drain correctly.
- FFT_OUTPUT_SCALE_EN defined, N=32, mem value {0x0100, 0xFF00} -> out_data {0x0008, 0xFFF8}. With the macro undefined -> {0x0100, 0xFF00}.
